// File: rtl/video_palout_if.sv
// Pixel strobe, palette write and RGB output bundle for the palette output stage.
interface video_palout_if;
  logic        pix_stb;
  logic        hres_stb;
  logic [7:0]  vplex_in;
  logic        hires;
  logic [3:0]  hpal;
  logic        blank;
  logic        cram_we;
  logic [7:0]  cram_addr;
  logic [14:0] cram_wdata;
  logic [14:0] rgb_out;
  logic        rgb_valid;

  modport master (
    output pix_stb, hres_stb, vplex_in, hires, hpal, blank,
    output cram_we, cram_addr, cram_wdata,
    input  rgb_out, rgb_valid
  );

  modport slave (
    input  pix_stb, hres_stb, vplex_in, hires, hpal, blank,
    input  cram_we, cram_addr, cram_wdata,
    output rgb_out, rgb_valid
  );
endinterface

// File: rtl/video_palout.sv
// Palette lookup: pixel index -> 15-bit colour through a 256x15 RAM, two-stage pipe.
// Latency 2 cycles from strobe to rgb_valid; one lookup per cycle, no backpressure.
module video_palout (
  input  logic          clk,
  input  logic          rst,
  video_palout_if.slave bus
);

  logic [14:0] r_pal [256];

  logic [3:0]  r_hold_nib;
  logic [3:0]  r_hold_hpal;
  logic        r_hold_hires;
  logic        r_hold_blank;

  logic        r_s1_vld;
  logic        r_s1_blank;
  logic [14:0] r_s1_word;

  logic [14:0] r_rgb;
  logic        r_rgb_vld;

  logic        w_lookup;
  logic [7:0]  w_index;
  logic        w_blank;
  logic [14:0] w_rd_word;

  // pix_stb has priority; hres_stb only replays the held second nibble.
  always_comb begin
    w_lookup = bus.pix_stb | (bus.hres_stb & r_hold_hires);
    w_index  = {r_hold_hpal, r_hold_nib};
    w_blank  = r_hold_blank;
    if (bus.pix_stb) begin
      w_index = bus.hires ? {bus.hpal, bus.vplex_in[7:4]} : bus.vplex_in;
      w_blank = bus.blank;
    end
  end

  // Same-cycle write to the looked-up entry returns the new colour.
  assign w_rd_word = (bus.cram_we && (bus.cram_addr == w_index)) ? bus.cram_wdata
                                                                 : r_pal[w_index];

  always_ff @(posedge clk) begin
    if (bus.cram_we) begin
      r_pal[bus.cram_addr] <= bus.cram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_lookup) begin
      r_s1_word <= w_rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_nib   <= 4'h0;
      r_hold_hpal  <= 4'h0;
      r_hold_hires <= 1'b0;
      r_hold_blank <= 1'b0;
    end else if (bus.pix_stb) begin
      r_hold_nib   <= bus.vplex_in[3:0];
      r_hold_hpal  <= bus.hpal;
      r_hold_hires <= bus.hires;
      r_hold_blank <= bus.blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_blank <= 1'b0;
      r_rgb      <= 15'h0;
      r_rgb_vld  <= 1'b0;
    end else begin
      r_s1_vld   <= w_lookup;
      r_s1_blank <= w_blank;
      r_rgb_vld  <= r_s1_vld;
      if (r_s1_vld) begin
        r_rgb <= r_s1_blank ? 15'h0 : r_s1_word;
      end
    end
  end

  assign bus.rgb_out   = r_rgb;
  assign bus.rgb_valid = r_rgb_vld;

endmodule

// File: doc/video_palout.md
VIDEO_PALOUT -- requirements
Module: video_palout

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port pix_stb  in  1  vplex_in/hires/blank valid this cycle, one per lo-res pixel.
REQ-005 SHALL have port hres_stb  in  1  mid-pixel strobe for the second hi-res pixel.
REQ-006 SHALL have port vplex_in  in  8  palette index, or two 4-bit pixels when hires (high nibble first).
REQ-007 SHALL have port hires  in  1  vplex_in carries two 4-bit pixels.
REQ-008 SHALL have port hpal  in  4  palette page prepended to 4-bit hi-res pixels.
REQ-009 SHALL have port blank  in  1  force black for this pixel period.
REQ-010 SHALL have port cram_we  in  1  palette RAM write enable.
REQ-011 SHALL have port cram_addr  in  8  palette RAM write address.
REQ-012 SHALL have port cram_wdata  in  15  colour {R[14:10],G[9:5],B[4:0]}.
REQ-013 SHALL have port rgb_out  out  15  output colour, same packing.
REQ-014 SHALL have port rgb_valid  out  1  one-cycle pulse: rgb_out updated.

Function
REQ-015 SHALL contain a 256x15 palette RAM, written when cram_we=1 at cram_addr, at any time, independent of strobes.
REQ-016 On pix_stb: index = hires ? {hpal, vplex_in[7:4]} : vplex_in; SHALL capture vplex_in[3:0], hpal, hires and blank into hold registers.
REQ-017 On hres_stb with held hires=1 and no pix_stb: index = {held hpal, held low nibble}, blank taken from the hold register.
REQ-018 hres_stb SHALL be ignored when held hires=0 or when pix_stb is also asserted (pix_stb wins).
REQ-019 Lookup stage 1: on the strobe cycle the RAM SHALL be read at index into a registered read word; a valid flag and blank SHALL be piped alongside.
REQ-020 Write/read collision: if cram_we=1 and cram_addr equals index in the strobe cycle, the read word SHALL be cram_wdata (new data).
REQ-021 Stage 2: the cycle after stage 1, rgb_out SHALL load blank ? 15'h0 : read word, and rgb_valid SHALL pulse for exactly that cycle.
REQ-022 Latency: strobe at edge N -> rgb_out/rgb_valid valid after edge N+2; throughput one lookup per cycle (back-to-back strobes fully pipelined).
REQ-023 rgb_out SHALL hold its value between rgb_valid pulses.
REQ-024 Writes arriving after the strobe cycle SHALL NOT alter a lookup already in flight.

Reset
REQ-025 While rst=1: rgb_out=15'h0, rgb_valid=0, pipeline valid flags=0, held hires=0, held blank=0, held nibble/hpal=0.
REQ-026 Palette RAM contents SHALL NOT be reset.
REQ-027 rst asserted mid-pipeline SHALL discard in-flight lookups; no rgb_valid pulse after rst deasserts until a new strobe.

Verification
REQ-028 Write idx 8'h3C=15'h7C00; pix_stb, vplex_in=8'h3C, hires=0, blank=0 at edge N -> rgb_out=15'h7C00, rgb_valid=1 at N+2 only.
REQ-029 Write 8'h5A=15'h03E0, 8'h57=15'h001F; pix_stb, hires=1, hpal=4'h5, vplex_in=8'hA7; hres_stb 2 cycles later -> 15'h03E0 then 15'h001F, two rgb_valid pulses.
REQ-030 Same cycle cram_we, cram_addr=8'h10, cram_wdata=15'h1234 and pix_stb vplex_in=8'h10 (old value 15'h0000) -> rgb_out=15'h1234.
REQ-031 pix_stb with blank=1, index holding 15'h7FFF -> rgb_out=15'h0000, rgb_valid=1; held hires=0 plus hres_stb -> no rgb_valid pulse.
REQ-032 pix_stb and hres_stb together with held hires=1 -> exactly one rgb_valid, colour from new vplex_in.
REQ-033 rst pulsed the cycle after pix_stb -> rgb_out=0, no rgb_valid pulse through 4 following cycles.
